jpeg_job_ctrl: RTL
==================

// Module: jpeg_job_ctrl
// PURPOSE
//  Sequences one JPEG decode job end to end: pulses decoder reset, meters a fixed number of
//  32-bit bitstream words from the host-side FIFO into the decoder, waits for the decoder to
//  go idle, and checks the emitted pixel count against width*height. Sits between the PCI
//  register/FIFO logic and jpeg_decode; its status drives the job-done interrupt and the LEDs.
// PARAMETERS
//  RST_CYCLES  16  decoder reset (dec_rst low) duration in clk cycles, >=1
//  IDLE_HOLD   4   consecutive cycles dec_idle must stay 1 before a job counts as finished
//  WORDS_W     24  width of job_words and the word counter
//  TMO_W       24  watchdog width; timeout fires after 2^TMO_W-1 cycles with no progress
// PORTS
//  clk             in   1        system clock (decoder clock domain)
//  rst             in   1        asynchronous reset, active low
//  job_start       in   1        1-cycle pulse; accepted only in IDLE or DONE
//  job_abort       in   1        level/pulse; aborts the active job
//  job_words       in   WORDS_W  bitstream length in 32-bit words; sampled on accepted job_start
//  src_valid       in   1        host FIFO not empty
//  src_data        in   32       host FIFO head word
//  src_read        out  1        pops host FIFO (= dec_in_en & dec_in_read)
//  dec_rst         out  1        decoder reset, active low
//  dec_in_data     out  32       = src_data (combinational)
//  dec_in_en       out  1        = src_valid & state==FEED & words_left!=0
//  dec_in_read     in   1        decoder consumes dec_in_data this cycle when dec_in_en=1
//  dec_idle        in   1        decoder idle flag
//  pix_en          in   1        decoder pixel strobe
//  pix_width       in   16       decoded image width
//  pix_height      in   16       decoded image height
//  job_busy        out  1        1 in RESET/FEED/DRAIN
//  job_done        out  1        1-cycle pulse on entry to DONE
//  job_err         out  2        0 ok, 1 timeout, 2 pixel-count mismatch, 3 aborted
//  pix_count       out  32       pixels seen since the job started
//  status          out  8        {job_err, state[2:0], dec_idle, job_busy, src_valid}
// BEHAVIOUR
//  Reset (rst low): state=IDLE, dec_rst=0 (decoder held in reset), job_busy=0, job_done=0,
//   job_err=0, pix_count=0, all counters 0. Async assert, release synchronous to clk.
//  States: IDLE(0), RESET(1), FEED(2), DRAIN(3), DONE(4).
//  IDLE/DONE: dec_rst=1 except while rst is low. job_start -> RESET; words_left<=job_words,
//   pix_count<=0, job_err<=0, rst counter<=RST_CYCLES.
//  RESET: dec_rst=0 for exactly RST_CYCLES cycles, then FEED with dec_rst=1.
//  FEED: each cycle with src_read=1 decrements words_left. When words_left reaches 0 (or is 0
//   on entry, e.g. job_words=0), go to DRAIN next cycle. src_read is never 1 when words_left=0.
//  DRAIN: idle counter increments while dec_idle=1 and clears when dec_idle=0. At IDLE_HOLD,
//   go to DONE; job_err=2 if pix_count != pix_width*pix_height (32-bit product, sampled then),
//   else 0.
//  pix_count increments on each pix_en while in FEED or DRAIN; saturates at 2^32-1.
//  Watchdog: cleared on src_read, pix_en, or a state change; counts in FEED/DRAIN only. At
//   all-ones -> DONE with job_err=1.
//  job_abort in RESET/FEED/DRAIN -> DONE with job_err=3 next cycle, src_read forced 0 in that
//   cycle; a following job_start re-resets the decoder. job_abort in IDLE/DONE is ignored.
//  job_abort has priority over completion/timeout in the same cycle; timeout has priority over
//   the DRAIN completion check.
//  job_start while busy is ignored; no queueing.
//  job_done pulses exactly once per job (normal, error, or abort), in the cycle DONE is entered.
// TESTING
//  job_words=8, FIFO always valid, dec_in_read=1 -> 8 src_read pulses in 8 consecutive FEED
//   cycles after 16 RESET cycles; done after IDLE_HOLD idle cycles.
//  8x8 image, 64 pix_en, job_words=4 -> job_done with job_err=0 and pix_count=64.
//  Same job with 63 pix_en -> job_err=2 and pix_count=63.
//  src_valid=0 forever in FEED (TMO_W=6 build) -> DONE after 63 stalled cycles, job_err=1.
//  job_abort in FEED with words_left=3 -> next cycle DONE, job_err=3, no further src_read;
//   a new job_start -> dec_rst low again for 16 cycles.
//  rst low mid-FEED -> all outputs at reset values immediately; job_start during busy is ignored.

Source files
------------

// File: rtl/jpeg_job_ctrl.sv
// Job sequencer for one JPEG decode: decoder reset pulse, metered bitstream feed,
// drain-until-idle and pixel-count check, with a no-progress watchdog and abort.
module jpeg_job_ctrl #(
   parameter int RST_CYCLES = 16,
   parameter int IDLE_HOLD  = 4,
   parameter int WORDS_W    = 24,
   parameter int TMO_W      = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_start,
   input  logic               job_abort,
   input  logic [WORDS_W-1:0] job_words,
   input  logic               src_valid,
   input  logic [31:0]        src_data,
   output logic               src_read,
   output logic               dec_rst,
   output logic [31:0]        dec_in_data,
   output logic               dec_in_en,
   input  logic               dec_in_read,
   input  logic               dec_idle,
   input  logic               pix_en,
   input  logic [15:0]        pix_width,
   input  logic [15:0]        pix_height,
   output logic               job_busy,
   output logic               job_done,
   output logic [1:0]         job_err,
   output logic [31:0]        pix_count,
   output logic [7:0]         status
);

   // state    | meaning
   // ST_IDLE  | no job since reset, decoder released
   // ST_RESET | decoder held in reset for RST_CYCLES cycles
   // ST_FEED  | metering job_words words from the host FIFO into the decoder
   // ST_DRAIN | all words delivered, waiting for IDLE_HOLD consecutive idle cycles
   // ST_DONE  | job finished (ok / timeout / pixel mismatch / abort), result held
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int RC_W = $clog2(RST_CYCLES + 1);
   localparam int IH_W = $clog2(IDLE_HOLD + 1);

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_TMO   = 2'd1;
   localparam logic [1:0] ERR_PIX   = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   state_t             state;
   logic [WORDS_W-1:0] words_left;
   logic [RC_W-1:0]    rst_cnt;
   logic [IH_W-1:0]    idle_cnt;
   logic [TMO_W-1:0]   wd_cnt;

   logic        in_run;
   logic        stalled;
   logic        timeout;
   logic        idle_hit;
   logic        last_word;
   logic [31:0] pix_nxt;
   logic [31:0] pix_area;

   assign dec_in_data = src_data;
   assign dec_in_en   = src_valid & (state == ST_FEED) & (words_left != '0);
   // an abort cycle must not pop a word the job will never account for
   assign src_read    = dec_in_en & dec_in_read & ~job_abort;

   assign in_run    = (state == ST_FEED) || (state == ST_DRAIN);
   assign stalled   = ~src_read & ~pix_en;
   assign timeout   = in_run & stalled & (wd_cnt == {{(TMO_W-1){1'b1}}, 1'b0});
   assign idle_hit  = dec_idle & (idle_cnt == IH_W'(IDLE_HOLD - 1));
   assign last_word = src_read & (words_left == WORDS_W'(1));
   assign pix_area  = {16'd0, pix_width} * {16'd0, pix_height};
   assign pix_nxt   = (in_run && pix_en && pix_count != '1) ? pix_count + 32'd1 : pix_count;

   assign status = {job_err, state, dec_idle, job_busy, src_valid};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         dec_rst    <= 1'b0;
         job_busy   <= 1'b0;
         job_done   <= 1'b0;
         job_err    <= ERR_OK;
         pix_count  <= '0;
         words_left <= '0;
         rst_cnt    <= '0;
         idle_cnt   <= '0;
         wd_cnt     <= '0;
      end else begin
         job_done  <= 1'b0;
         pix_count <= pix_nxt;
         if (src_read) words_left <= words_left - WORDS_W'(1);
         if (in_run) wd_cnt <= stalled ? wd_cnt + TMO_W'(1) : '0;

         case (state)
            ST_IDLE, ST_DONE: begin
               dec_rst <= 1'b1;
               if (job_start) begin
                  state      <= ST_RESET;
                  dec_rst    <= 1'b0;
                  job_busy   <= 1'b1;
                  job_err    <= ERR_OK;
                  words_left <= job_words;
                  pix_count  <= '0;
                  rst_cnt    <= RC_W'(RST_CYCLES);
               end
            end
            ST_RESET: begin
               if (job_abort) begin
                  state    <= ST_DONE;
                  dec_rst  <= 1'b1;
                  job_busy <= 1'b0;
                  job_done <= 1'b1;
                  job_err  <= ERR_ABORT;
               end else if (rst_cnt == RC_W'(1)) begin
                  state   <= ST_FEED;
                  dec_rst <= 1'b1;
                  wd_cnt  <= '0;
               end else begin
                  rst_cnt <= rst_cnt - RC_W'(1);
               end
            end
            ST_FEED: begin
               if (job_abort || timeout) begin
                  state    <= ST_DONE;
                  job_busy <= 1'b0;
                  job_done <= 1'b1;
                  job_err  <= job_abort ? ERR_ABORT : ERR_TMO;
               end else if (words_left == '0 || last_word) begin
                  state    <= ST_DRAIN;
                  idle_cnt <= '0;
                  wd_cnt   <= '0;
               end
            end
            ST_DRAIN: begin
               if (job_abort || timeout || idle_hit) begin
                  state    <= ST_DONE;
                  job_busy <= 1'b0;
                  job_done <= 1'b1;
                  if (job_abort)               job_err <= ERR_ABORT;
                  else if (timeout)            job_err <= ERR_TMO;
                  else if (pix_nxt != pix_area) job_err <= ERR_PIX;
                  else                         job_err <= ERR_OK;
               end else begin
                  idle_cnt <= dec_idle ? idle_cnt + IH_W'(1) : '0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               job_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
